rr_arb_4_1: RTL and testbench
=============================

Name: rr_arb_4_1

Overview:
- Round-robin arbiter with a registered output stage, sitting directly upstream of the 4:1 data select path.
- It takes four request/data channels, picks one per cycle using a rotating priority, and produces the winning data plus its 2-bit select index.
- It drives a single valid/ready output towards the consumer.
- It turns the combinational 4:1 mux into a fair, flow-controlled 4-to-1 merge stage.

Parameters:
- W, 4, data width of each channel and of out_data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-channel request; req[i] means d<i> holds a valid word.
- d0, d1, d2, d3  input  W each  channel data.
- gnt  output  4  one-hot acknowledge; gnt[i]=1 means d<i> is captured at this clock edge.
- out_valid  output  1  out_data/out_sel hold a valid word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  W  registered winning data.
- out_sel  output  2  registered index of the winning channel.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
  - gnt is forced to 0 while rst_n=0.
- Reset mid-operation: a held, unaccepted word is discarded. No gnt is issued in any cycle where rst_n=0.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load condition: load = (EMPTY || (FULL && out_ready)) && |req.
- Pick (combinational): winner i is the first index with req[i]=1, searching ptr, ptr+1, ... mod 4.
- Grant: gnt = onehot(i) when load, else 0.
  - Combinational from req, out_valid, out_ready and ptr.
  - At most one bit set.
- On a load edge:
  - out_data <= d<i>, out_sel <= i, out_valid <= 1.
  - ptr <= (i+1) mod 4; the 2-bit wrap from 3 to 0 is natural.
- Unload without reload: FULL && out_ready && !|req → out_valid <= 0 (EMPTY). out_data and out_sel keep their last values.
- Stall: FULL && !out_ready → out_data, out_sel, out_valid and ptr hold, and gnt=0.
- Latency and throughput:
  - Request to out_valid is 1 cycle.
  - Throughput is 1 word per cycle when out_ready stays high (simultaneous unload and load in FULL).
- Sources:
  - A source keeps req[i] and d<i> stable until it sees gnt[i]=1 at a clock edge.
  - It may present the next word in the following cycle.
- Fairness: a continuously requesting channel is granted within 4 loads.
- ptr advances only on a load, never on an idle or stalled cycle.
- X-propagation: data of non-selected channels does not affect out_data.

Decomposition:
- Package rr_arb_pkg:
  - localparam N_CH=4, SEL_W=2.
  - function next_ptr(sel) returning (sel+1) mod N_CH.
- Sub-module rr_pick_4 (combinational):
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, sel[1:0], onehot[3:0].
- Data selection: a 4:1 mux indexed by the picked sel (the team's mux_4_1 for W=4), feeding the out_data register.

Test Plan:
- Reset: hold rst_n=0 with req=4'hF → gnt=0, out_valid=0, out_data=0, out_sel=0. Release rst_n; first edge with out_ready=1 → out_sel=0, out_data=d0.
- Rotation: req=4'hF continuously, d0..d3=A,B,C,D, out_ready=1.
  - out_sel sequence 0,1,2,3,0 on consecutive cycles.
  - out_data A,B,C,D,A.
  - gnt sequence 1,2,4,8,1.
- Skip and wrap: ptr=3 after granting ch2, req=4'b0101 → next grant ch0 (gnt=4'b0001), then ch2.
- Backpressure: FULL with out_sel=1, out_data=B, out_ready=0 for 3 cycles and req=4'hF.
  - gnt=0 throughout; outputs hold B/1.
  - out_ready=1 → same cycle gnt=4'b0100, next cycle out_data=C.
- Drain: single req[3] pulse with d3=7, then req=0, out_ready=1 → out_valid high exactly 1 cycle with out_data=7, out_sel=3, then EMPTY.
- Async reset mid-stall: FULL, out_ready=0, drop rst_n between edges → out_valid falls immediately without a clock, and ptr=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-channel round-robin arbiter.
//   N_CH     : number of request channels
//   SEL_W    : width of a channel index
//   arb_state_e : output-stage occupancy (EMPTY / FULL)
//   next_ptr : priority pointer value after granting channel sel
package rr_arb_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // The winner gets lowest priority next time; the 2-bit add wraps 3 -> 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] sel);
        return sel + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker.
//   req    [3:0] : per-channel request
//   ptr    [1:0] : channel with highest priority this cycle
//   any          : at least one request present
//   sel    [1:0] : first requesting channel searching ptr, ptr+1, ... mod 4
//   onehot [3:0] : one-hot of sel, all zero when no request
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  onehot
);

    // rot_req[k] is the request of the channel k places after ptr.
    logic [N_CH-1:0]  rot_req;
    logic [SEL_W-1:0] rot_idx [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_rot
            assign rot_idx[gi] = ptr + SEL_W'(gi);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest requester to ptr overwrites last.
    always_comb begin
        any = |req;
        sel = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                sel = rot_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_onehot
            assign onehot[gi] = any && (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arb_4_1.sv
// Round-robin 4-to-1 merge stage with a registered, flow-controlled output.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req   [3:0]    : per-channel request, d<i> valid while req[i]
//   d0..d3 [W-1:0] : channel data
//   gnt   [3:0]    : one-hot, d<i> captured at this clock edge
//   out_valid      : out_data/out_sel hold a word
//   out_ready      : consumer takes the word when out_valid && out_ready
//   out_data [W-1:0], out_sel [1:0] : registered winning word and its index
module rr_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_CH-1:0]  gnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel
);

    arb_state_e       state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [W-1:0]     out_data_reg, out_data_next;
    logic [SEL_W-1:0] out_sel_reg, out_sel_next;

    logic             pick_any;
    logic [SEL_W-1:0] pick_sel;
    logic [N_CH-1:0]  pick_onehot;
    logic [W-1:0]     sel_data;
    logic             load;

    rr_pick_4 u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .any    (pick_any),
        .sel    (pick_sel),
        .onehot (pick_onehot)
    );

    // 4:1 data select driven only by the picked index, so unselected
    // channels (even X) never reach the output register.
    always_comb begin
        sel_data = '0;
        case (pick_sel)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            2'd3:    sel_data = d3;
            default: sel_data = '0;
        endcase
    end

    // rst_n is part of load so no grant can leak out while reset is held.
    assign load = rst_n && pick_any && ((state_reg == ST_EMPTY) || out_ready);
    assign gnt  = load ? pick_onehot : '0;

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        out_data_next = out_data_reg;
        out_sel_next  = out_sel_reg;
        if (load) begin
            state_next    = ST_FULL;
            ptr_next      = next_ptr(pick_sel);
            out_data_next = sel_data;
            out_sel_next  = pick_sel;
        end else if ((state_reg == ST_FULL) && out_ready) begin
            // Drained with nothing to replace it; data/sel keep last values.
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            ptr_reg      <= '0;
            out_data_reg <= '0;
            out_sel_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            out_data_reg <= out_data_next;
            out_sel_reg  <= out_sel_next;
        end
    end

    assign out_valid = (state_reg == ST_FULL);
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_arb_4_1.sv
module tb_rr_arb_4_1;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] gnt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;

    rr_arb_4_1 #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // Scoreboard consumer: a word is taken at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got sel=%0d data=%h, none expected", out_sel, out_data);
            end else begin
                e_mon = sb.pop_front();
                if (out_sel !== e_mon.sel || out_data !== e_mon.data) begin
                    bad++;
                    $display("FAIL out_word: got sel=%0d data=%h, want sel=%0d data=%h",
                             out_sel, out_data, e_mon.sel, e_mon.data);
                end else begin
                    $display("word sel=%0d data=%h ok", out_sel, out_data);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = 4'h0;
        out_ready = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        d0 = 4'h3; d1 = 4'h5; d2 = 4'h6; d3 = 4'h9;
        req = 4'hF;
        out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (gnt !== 4'h0) begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", out_sel); end
        $display("reset hold checked");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL rst_first_gnt: got %b want 0001", gnt); end
        sb.push_back('{sel: 2'd0, data: 4'h3});
        @(posedge clk); #1;
        req = 4'h0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_first_valid: got %b want 1", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_rotation();
        logic [3:0] vals [4];
        logic [3:0] eg;
        vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
        do_reset();
        d0 = vals[0]; d1 = vals[1]; d2 = vals[2]; d3 = vals[3];
        req = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            eg = 4'b0001 << (k % 4);
            total++;
            if (gnt !== eg) begin bad++; $display("FAIL rot_gnt%0d: got %b want %b", k, gnt, eg); end
            else $display("rotation step %0d gnt=%b", k, gnt);
            sb.push_back('{sel: 2'(k % 4), data: vals[k % 4]});
            @(posedge clk); #1;
        end
        req = 4'h0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h9; d3 = 4'h3;
        out_ready = 1'b1;
        req = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL skip_gnt_a: got %b want 0100", gnt); end
        sb.push_back('{sel: 2'd2, data: 4'h9});
        @(posedge clk); #1;
        req = 4'b0101;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL skip_gnt_wrap: got %b want 0001", gnt); end
        sb.push_back('{sel: 2'd0, data: 4'h5});
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL skip_gnt_b: got %b want 0100", gnt); end
        sb.push_back('{sel: 2'd2, data: 4'h9});
        $display("skip and wrap sequence driven");
        @(posedge clk); #1;
        req = 4'h0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_backpressure();
        do_reset();
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        out_ready = 1'b1;
        req = 4'b0010;
        @(negedge clk);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL bp_first_gnt: got %b want 0010", gnt); end
        sb.push_back('{sel: 2'd1, data: 4'hB});
        @(posedge clk); #1;
        req = 4'hF;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== 4'h0 || out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'hB) begin
                bad++;
                $display("FAIL bp_hold%0d: got gnt=%b v=%b sel=%0d data=%h want 0000/1/1/b",
                         k, gnt, out_valid, out_sel, out_data);
            end else $display("stall cycle %0d holding", k);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL bp_release_gnt: got %b want 0100", gnt); end
        sb.push_back('{sel: 2'd2, data: 4'hC});
        @(posedge clk); #1;
        req = 4'h0;
        @(negedge clk);
        total++; if (out_data !== 4'hC) begin bad++; $display("FAIL bp_next_data: got %h want c", out_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_drain();
        do_reset();
        d3 = 4'h7;
        out_ready = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL drain_gnt: got %b want 1000", gnt); end
        sb.push_back('{sel: 2'd3, data: 4'h7});
        @(posedge clk); #1;
        req = 4'h0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drain_valid1: got %b want 1", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0", out_valid); end
        total++;
        if (out_data !== 4'h7 || out_sel !== 2'd3) begin
            bad++;
            $display("FAIL drain_keep: got sel=%0d data=%h want 3/7", out_sel, out_data);
        end else $display("drain to empty checked");
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset_stall();
        do_reset();
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h9; d3 = 4'h3;
        out_ready = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ars_gnt: got %b want 0001", gnt); end
        sb.push_back('{sel: 2'd0, data: 4'h5});
        @(posedge clk); #1;
        req = 4'hF;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ars_full: got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || gnt !== 4'h0) begin
            bad++;
            $display("FAIL ars_async: got v=%b data=%h gnt=%b want 0/0/0000", out_valid, out_data, gnt);
        end else $display("async reset cleared outputs");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL ars_ptr0: got %b want 0001", gnt); end
        sb.push_back('{sel: 2'd0, data: 4'h5});
        @(posedge clk); #1;
        req = 4'h0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_n = 1'b1;
        req = 4'h0;
        out_ready = 1'b0;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_backpressure();
        test_drain();
        test_async_reset_stall();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d words pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
